ctrl_barrido_less3b: RTL
========================

Name: ctrl_barrido_less3b

Overview:
Sequencer that exhaustively exercises one instance of the 3-bit "less-than-3" comparator datapath (input ABC, output F) in-system. On each start it drives all 8 input codes, waits a settle window per code, samples F, and checks it against the expected value (code < THRESH). It accumulates a captured truth table, an error count and the first failing code. It sits beside the comparator as a built-in self-test controller, and its results are read by status logic.

Parameters:
SETTLE_CYCLES, 1, extra cycles each code is held before F is sampled; range 0..15.
THRESH, 3, expected F = 1 when code < THRESH, else 0; range 0..8.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  level-sampled scan request; honoured only in IDLE
abort  in  1  synchronous scan cancel
abc_o  out  3  code driven to comparator ABC
f_i  in  1  comparator F output
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse at scan completion
pass  out  1  1 = last completed scan had zero mismatches
err_count  out  4  mismatches in last scan, 0..8
tabla  out  8  captured F, bit[n] = F sampled for code n
first_err_code  out  3  first mismatching code in visit order
err_flag  out  1  1 = first_err_code is valid

Behaviour:
- Reset values (next edge with rst=1, from any state): abc_o=0, busy=0, done=0, pass=0, err_count=0, tabla=0, first_err_code=0, err_flag=0. State is IDLE and the settle counter is 0. A reset mid-scan discards the scan; no done pulse is generated.
- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - start=1 and abort=0 at an edge moves to SETTLE (or SAMPLE if SETTLE_CYCLES=0).
  - That same edge sets abc_o=first code and busy=1, and clears pass, err_count, tabla, first_err_code and err_flag.
- SETTLE: counts SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE (one cycle): at its closing edge:
  - tabla[abc_o] <= f_i.
  - On mismatch (f_i != (abc_o < THRESH)): err_count += 1. If err_flag=0, set first_err_code=abc_o and err_flag=1.
  - If codes remain, advance abc_o to the next code and return to SETTLE (or SAMPLE).
  - After the 8th code: busy->0, done->1, pass->(final err_count==0), state->IDLE, abc_o->0.
- Each code is held for exactly SETTLE_CYCLES+1 cycles. busy is high for 8*(SETTLE_CYCLES+1) cycles. done is high exactly one cycle, coincident with the first cycle busy=0.
- Results (pass, err_count, tabla, first_err_*) hold until the next accepted start or rst.
- start while busy=1 is ignored; no restart or queueing.
- abort=1 in SETTLE or SAMPLE:
  - Next edge: IDLE, busy=0, abc_o=0, pass=0, no done.
  - tabla, err_count and first_err_* keep their partial values.
  - An SAMPLE-cycle abort wins over capture; the current code is not recorded.
- abort=1 together with start in IDLE: abort wins; no scan starts.
- Visit order: ascending 0..7.
- err_count is 4 bits and cannot wrap (max 8).
- f_i is treated as synchronous to clk; there is no synchroniser.

Optional Feature:
Macro CTRL_BARRIDO_LESS3B_LFSR_EN.
- Defined: visit order is 0, then a 3-bit Fibonacci LFSR seeded 3'b001 with next = {s[1:0], s[2]^s[1]}. This gives 0,1,2,5,3,7,6,4. The LFSR reseeds on every accepted start. Timing, tabla indexing, err_count and pass are identical to the ascending mode; first_err_code reflects the LFSR order.
- Not defined: no LFSR logic is present; order is ascending 0..7.

Test Plan:
1. Good comparator model, SETTLE_CYCLES=1, start pulse -> abc_o 0..7 each held 2 cycles, busy high 16 cycles, done one-cycle pulse at the 17th cycle. Results: tabla=8'b0000_0111, err_count=0, err_flag=0, pass=1.
2. f_i stuck at 1 -> tabla=8'hFF, err_count=5, first_err_code=3, err_flag=1, pass=0. With the macro defined, first_err_code=5 and all other results are unchanged.
3. SETTLE_CYCLES=0, faulty model F=(ABC<=3) -> abc_o changes every cycle, busy=8 cycles. Results: tabla=8'b0000_1111, err_count=1, first_err_code=3, pass=0.
4. abort at the 5th busy cycle -> busy=0 and abc_o=0 the next cycle, done never asserts, pass=0. A following start clears the results and completes a clean scan with pass=1.
5. Second start at busy cycle 3 -> ignored; exactly one done pulse after 16 cycles. Then rst at busy cycle 6 of a new scan -> all outputs at reset values next cycle, no done.
6. start and abort together in IDLE -> busy stays 0, outputs unchanged. With the macro defined, the abc_o sequence is 0,1,2,5,3,7,6,4 on every scan.

Source files
------------

// File: rtl/ctrl_barrido_less3b_if.sv
// Scan-control, result and comparator-drive signals of the less-than-3 BIST sequencer.
// slave = sequencer side, master = requester/comparator side.
interface ctrl_barrido_less3b_if;
    logic       start;
    logic       abort;
    logic [2:0] abc_o;
    logic       f_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] tabla;
    logic [2:0] first_err_code;
    logic       err_flag;

    modport master (
        output start, abort, f_i,
        input  abc_o, busy, done, pass, err_count, tabla, first_err_code, err_flag
    );

    modport slave (
        input  start, abort, f_i,
        output abc_o, busy, done, pass, err_count, tabla, first_err_code, err_flag
    );
endinterface

// File: rtl/ctrl_barrido_less3b.sv
// BIST sequencer sweeping all 8 codes of the less-than comparator; CTRL_BARRIDO_LESS3B_LFSR_EN selects LFSR visit order.
// Latency: 8*(SETTLE_CYCLES+1) cycles from accepted start to the one-cycle done pulse.
// Backpressure: none; start is ignored while busy, abort cancels the scan at the next edge.
module ctrl_barrido_less3b #(
    parameter int SETTLE_CYCLES = 1,
    parameter int THRESH        = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    ctrl_barrido_less3b_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] THRESH_L    = 4'(THRESH);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam bool_settle_skip_dummy  = 0;
    localparam state_t     HOLD_STATE  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

`ifdef CTRL_BARRIDO_LESS3B_LFSR_EN
    localparam logic [2:0] LAST_CODE = 3'd4;
`else
    localparam logic [2:0] LAST_CODE = 3'd7;
`endif

    state_t     state_q, state_d;
    logic [3:0] settle_cnt_q;

    logic [2:0] abc_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_count_q;
    logic [7:0] tabla_q;
    logic [2:0] first_err_code_q;
    logic       err_flag_q;

    logic       busy_c;
    logic       accept_c;
    logic       cancel_c;
    logic       capture_c;
    logic       mismatch_c;
    logic       last_c;
    logic [3:0] err_cnt_nxt_c;
    logic [2:0] code_nxt_c;

    // State register and settle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            if (state_q == SETTLE && state_d == SETTLE) begin
                settle_cnt_q <= settle_cnt_q + 4'd1;
            end else begin
                settle_cnt_q <= 4'd0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = HOLD_STATE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bus.abort || abc_q == LAST_CODE) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD_STATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        busy_c        = (state_q != IDLE);
        accept_c      = (state_q == IDLE) && bus.start && !bus.abort;
        cancel_c      = busy_c && bus.abort;
        capture_c     = (state_q == SAMPLE) && !bus.abort;
        mismatch_c    = (bus.f_i != ({1'b0, abc_q} < THRESH_L));
        last_c        = (abc_q == LAST_CODE);
        err_cnt_nxt_c = err_count_q + {3'b000, mismatch_c};
`ifdef CTRL_BARRIDO_LESS3B_LFSR_EN
        // Code 0 is visited first and then seeds the LFSR, so every scan restarts the sequence.
        if (abc_q == 3'd0) begin
            code_nxt_c = 3'b001;
        end else begin
            code_nxt_c = {abc_q[1:0], abc_q[2] ^ abc_q[1]};
        end
`else
        code_nxt_c = abc_q + 3'd1;
`endif
    end

    // Result datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            abc_q            <= 3'd0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= 4'd0;
            tabla_q          <= 8'd0;
            first_err_code_q <= 3'd0;
            err_flag_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_c) begin
                abc_q            <= 3'd0;
                pass_q           <= 1'b0;
                err_count_q      <= 4'd0;
                tabla_q          <= 8'd0;
                first_err_code_q <= 3'd0;
                err_flag_q       <= 1'b0;
            end else if (cancel_c) begin
                abc_q  <= 3'd0;
                pass_q <= 1'b0;
            end else if (capture_c) begin
                tabla_q[abc_q] <= bus.f_i;
                err_count_q    <= err_cnt_nxt_c;
                if (mismatch_c && !err_flag_q) begin
                    first_err_code_q <= abc_q;
                    err_flag_q       <= 1'b1;
                end
                if (last_c) begin
                    abc_q  <= 3'd0;
                    done_q <= 1'b1;
                    pass_q <= (err_cnt_nxt_c == 4'd0);
                end else begin
                    abc_q <= code_nxt_c;
                end
            end
        end
    end

    assign bus.abc_o          = abc_q;
    assign bus.busy           = busy_c;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_count_q;
    assign bus.tabla          = tabla_q;
    assign bus.first_err_code = first_err_code_q;
    assign bus.err_flag       = err_flag_q;

    a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done_q |-> !busy_c);
    a_err_bounded:   assert property (@(posedge clk) disable iff (rst) err_count_q <= 4'd8);
    a_pass_clean:    assert property (@(posedge clk) disable iff (rst) pass_q |-> (err_count_q == 4'd0));

endmodule
